dram4164_ctrl: RTL and testbench

- Clocked sequencer for a 64 KB bank of eight parallel 4164 DRAMs, one chip per data bit; all chips share MA/RAS/CAS/WE.
- Turns single-beat host read/write requests into multiplexed row/column strobe sequences.
- All writes are early writes: nwe goes low before ncas.
- Inserts RAS-only refresh cycles from an internal interval timer. Refresh has priority over host requests.
- Sits between the bus/memory-mapper logic and the DRAM bank.

---
 rtl/dram4164_ctrl_if.sv | 13 +
 rtl/dram4164_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dram4164_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dram4164_ctrl_if.sv
// Host-side request/acknowledge bus of the 4164 DRAM bank controller.
interface dram4164_ctrl_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        ack;
   logic [7:0]  rdata;
   logic        busy;

   modport master (output req, we, addr, wdata, input  ack, rdata, busy);
   modport slave  (input  req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/dram4164_ctrl.sv
// Row/column strobe sequencer for an 8 x 4164 DRAM bank with RAS-only refresh.
//
// state | meaning
// IDLE  | strobes high; refresh or host request may start here
// ROW   | nras low, ma = row address
// COLA  | ma = column address, nwe set for early write
// CAS   | ncas low; read data sampled as the window closes
// REF   | RAS-only refresh of the current refresh row
// PRE   | precharge; the IDLE cycle that follows also counts as precharge
module dram4164_ctrl #(
   parameter int T_RAS_MUX    = 1,
   parameter int T_MUX_CAS    = 1,
   parameter int T_CAS        = 4,
   parameter int T_PRE        = 2,
   parameter int T_REF_RAS    = 4,
   parameter int REF_INTERVAL = 330
) (
   input  logic            clk,
   input  logic            nreset,
   dram4164_ctrl_if.slave  host,
   output logic [7:0]      ma,
   output logic            nras,
   output logic            ncas,
   output logic            nwe,
   output logic [7:0]      dout,
   input  logic [7:0]      din
);

   localparam int CW = $clog2(T_RAS_MUX + T_MUX_CAS + T_CAS + T_PRE + T_REF_RAS + 1);
   localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ROW, S_COLA, S_CAS, S_REF, S_PRE} state_t;

   // With T_PRE = 1 the IDLE decision cycle alone provides the precharge.
   localparam state_t         S_AFTER  = (T_PRE > 1) ? S_PRE : S_IDLE;
   localparam logic [CW-1:0]  LD_ROW   = CW'(T_RAS_MUX - 1);
   localparam logic [CW-1:0]  LD_COLA  = CW'(T_MUX_CAS - 1);
   localparam logic [CW-1:0]  LD_CAS   = CW'(T_CAS - 1);
   localparam logic [CW-1:0]  LD_REF   = CW'(T_REF_RAS - 1);
   localparam logic [CW-1:0]  LD_PRE   = CW'((T_PRE > 1) ? T_PRE - 2 : 0);
   localparam logic [TW-1:0]  TMR_LOAD = TW'(REF_INTERVAL - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           pend_q, pend_d;
   logic [7:0]     ref_row_q, ref_row_d;
   logic [7:0]     col_q, col_d;
   logic           we_q, we_d;
   logic [7:0]     ma_q, ma_d;
   logic           nras_q, nras_d;
   logic           ncas_q, ncas_d;
   logic           nwe_q, nwe_d;
   logic [7:0]     dout_q, dout_d;
   logic           ack_q, ack_d;
   logic [7:0]     rdata_q, rdata_d;
   logic           busy_q, busy_d;

   // State and registered outputs; async reset drops the strobes without a clock.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tmr_q     <= TMR_LOAD;
         pend_q    <= 1'b0;
         ref_row_q <= 8'd0;
         col_q     <= 8'd0;
         we_q      <= 1'b0;
         ma_q      <= 8'd0;
         nras_q    <= 1'b1;
         ncas_q    <= 1'b1;
         nwe_q     <= 1'b1;
         dout_q    <= 8'd0;
         ack_q     <= 1'b0;
         rdata_q   <= 8'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         pend_q    <= pend_d;
         ref_row_q <= ref_row_d;
         col_q     <= col_d;
         we_q      <= we_d;
         ma_q      <= ma_d;
         nras_q    <= nras_d;
         ncas_q    <= ncas_d;
         nwe_q     <= nwe_d;
         dout_q    <= dout_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
      end
   end

   // Next state and phase timer; refresh wins over a simultaneous request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_REF;
               cnt_d   = LD_REF;
            end else if (host.req) begin
               state_d = S_ROW;
               cnt_d   = LD_ROW;
            end
         end
         S_ROW: begin
            if (cnt_q == '0) begin
               state_d = S_COLA;
               cnt_d   = LD_COLA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_COLA: begin
            if (cnt_q == '0) begin
               state_d = S_CAS;
               cnt_d   = LD_CAS;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_CAS, S_REF: begin
            if (cnt_q == '0) begin
               state_d = S_AFTER;
               cnt_d   = LD_PRE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_PRE: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of strobes, address mux, data paths and the refresh timer.
   always_comb begin
      ma_d      = ma_q;
      nras_d    = nras_q;
      ncas_d    = ncas_q;
      nwe_d     = nwe_q;
      dout_d    = dout_q;
      rdata_d   = rdata_q;
      col_d     = col_q;
      we_d      = we_q;
      ref_row_d = ref_row_q;
      ack_d     = 1'b0;
      busy_d    = (state_d != S_IDLE);
      pend_d    = pend_q;
      tmr_d     = (tmr_q == '0) ? TMR_LOAD : tmr_q - TW'(1);
      case (state_q)
         S_IDLE: begin
            if (state_d == S_REF) begin
               nras_d = 1'b0;
               ma_d   = ref_row_q;
               pend_d = 1'b0;
            end else if (state_d == S_ROW) begin
               nras_d = 1'b0;
               ma_d   = host.addr[15:8];
               col_d  = host.addr[7:0];
               we_d   = host.we;
               dout_d = host.wdata;
            end
         end
         S_ROW: begin
            if (state_d == S_COLA) begin
               ma_d  = col_q;
               nwe_d = ~we_q;
            end
         end
         S_COLA: begin
            if (state_d == S_CAS) ncas_d = 1'b0;
         end
         S_CAS: begin
            if (state_d != S_CAS) begin
               nras_d = 1'b1;
               ncas_d = 1'b1;
               nwe_d  = 1'b1;
               ack_d  = 1'b1;
               if (!we_q) rdata_d = din;
            end
         end
         S_REF: begin
            if (state_d != S_REF) begin
               nras_d    = 1'b1;
               ref_row_d = ref_row_q + 8'd1;
            end
         end
         default: ;
      endcase
      // A tick that coincides with refresh entry still leaves a refresh owed.
      if (tmr_q == '0) pend_d = 1'b1;
   end

   assign ma         = ma_q;
   assign nras       = nras_q;
   assign ncas       = ncas_q;
   assign nwe        = nwe_q;
   assign dout       = dout_q;
   assign host.ack   = ack_q;
   assign host.rdata = rdata_q;
   assign host.busy  = busy_q;

endmodule

// File: tb/tb_dram4164_ctrl.sv
// Scoreboard bench for dram4164_ctrl with a behavioural 4164 bank model.
module tb_dram4164_ctrl;
   localparam int REF_IV = 100;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic [7:0] ma, dout, din;
   logic       nras, ncas, nwe;
   int         cyc = 0;

   dram4164_ctrl_if host ();

   dram4164_ctrl #(.REF_INTERVAL(REF_IV)) dut (
      .clk(clk), .nreset(nreset), .host(host),
      .ma(ma), .nras(nras), .ncas(ncas), .nwe(nwe), .dout(dout), .din(din)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DRAM bank model: early-write data captured at ncas fall, committed when
   // the cycle closes normally so an access cut off by reset leaves no trace.
   logic [7:0] mem [0:65535];
   logic [7:0] row_l = 8'd0, col_l = 8'd0, wd_l = 8'd0;
   logic       wr_l = 1'b0;
   initial for (int i = 0; i < 65536; i++) mem[i] = 8'h5C ^ i[7:0] ^ i[15:8];
   always @(negedge nras) row_l = ma;
   always @(negedge ncas) begin
      col_l = ma;
      wr_l  = !nwe;
      wd_l  = dout;
   end
   always @(posedge ncas) begin
      if (wr_l && nreset) mem[{row_l, col_l}] = wd_l;
      wr_l = 1'b0;
   end
   assign din = ncas ? 8'hEE : mem[{row_l, col_l}];

   int n_vec = 0, n_miss = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard: {we, expected rdata} pushed at issue, popped on ack.
   typedef struct packed {logic we; logic [7:0] rd;} exp_t;
   exp_t sb_q[$];
   exp_t sb_e;
   int   ack_cnt = 0;

   // Refresh bookkeeping: a refresh is an nras pulse during which ncas never fell.
   logic       prev_nras = 1'b1, prev_ncas = 1'b1;
   logic [7:0] prev_ma = 8'd0, prev_dout = 8'd0;
   int         pulse_w = 0, pulse_cyc = 0, ref_cyc = 0, ref_count = 0;
   logic [7:0] pulse_ma = 8'd0, exp_ref_row = 8'd0;
   logic       pulse_cas = 1'b0;
   logic [7:0] ref_hist[$];

   // Monitor: strobe rules, refresh rows and widths, ack/rdata against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (nreset) begin
         if (!nwe && nras) chk("nwe_low_with_nras_high", 1, 0);
         if (!ncas && !prev_ncas && ma !== prev_ma) chk("ma_stable_under_cas", ma, prev_ma);
         if (!nras && !prev_nras && dout !== prev_dout) chk("dout_stable_under_ras", dout, prev_dout);
         if (prev_nras && !nras) begin
            pulse_w = 1; pulse_ma = ma; pulse_cas = 1'b0; pulse_cyc = cyc;
         end else if (!nras) begin
            pulse_w++;
            if (!ncas) pulse_cas = 1'b1;
         end else if (!prev_nras && !pulse_cas) begin
            chk("ref_row", pulse_ma, exp_ref_row);
            chk("ref_width", pulse_w, 4);
            ref_hist.push_back(pulse_ma);
            exp_ref_row = exp_ref_row + 8'd1;
            ref_cyc = pulse_cyc;
            ref_count++;
         end
         if (host.ack) begin
            ack_cnt++;
            if (sb_q.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               sb_e = sb_q.pop_front();
               if (!sb_e.we) chk("read_data", host.rdata, sb_e.rd);
            end
         end
      end
      prev_nras = nras; prev_ncas = ncas; prev_ma = ma; prev_dout = dout;
   end

   // Per-cycle trace of an access; index 0 is the negedge after the first edge that sees req.
   logic       s_nras[40], s_ncas[40], s_nwe[40];
   logic [7:0] s_ma[40];

   task automatic traced(input logic we1, input logic [15:0] a1, input logic [7:0] d1,
                         input logic [7:0] e1, input int n_ops, input logic we2,
                         input logic [15:0] a2, input logic [7:0] e2,
                         output int k1, output int k2);
      k1 = -1; k2 = -1;
      sb_q.push_back({we1, e1});
      host.we = we1; host.addr = a1; host.wdata = d1; host.req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         s_nras[k] = nras; s_ncas[k] = ncas; s_nwe[k] = nwe; s_ma[k] = ma;
         if (host.ack) begin
            if (k1 < 0) begin
               k1 = k;
               if (n_ops == 2) begin
                  sb_q.push_back({we2, e2});
                  host.we = we2; host.addr = a2;
               end else begin
                  host.req = 1'b0;
                  break;
               end
            end else begin
               k2 = k;
               host.req = 1'b0;
               break;
            end
         end
      end
      if (host.req) begin
         host.req = 1'b0;
         chk("ack_timeout", 0, 1);
      end
   endtask

   task automatic sync_ref();
      int c0 = ref_count;
      int g = 0;
      while (ref_count == c0 && g < 3 * REF_IV) begin
         @(negedge clk);
         g++;
      end
      if (ref_count == c0) chk("refresh_timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, expected summary");
      $fatal(1);
   end

   initial begin
      int k1, k2, a0, rc, g;
      host.req = 1'b0; host.we = 1'b0; host.addr = 16'h0; host.wdata = 8'h0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_nras", nras, 1); chk("rst_ncas", ncas, 1); chk("rst_nwe", nwe, 1);
      chk("rst_ma", ma, 0); chk("rst_dout", dout, 0); chk("rst_ack", host.ack, 0);
      chk("rst_rdata", host.rdata, 0); chk("rst_busy", host.busy, 0);
      nreset = 1'b1;

      // Idle refresh: three RAS-only cycles, rows 0,1,2, width 4
      repeat (3 * REF_IV + 20) @(negedge clk);
      chk("idle_ref_count", ref_count, 3);

      // Write 0xA5 to 0x1234 then read it back
      sync_ref();
      traced(1'b1, 16'h1234, 8'hA5, 8'h00, 1, 1'b0, 16'h0, 8'h0, k1, k2);
      chk("wr_ack_edge", k1, 6);
      chk("wr_nras_fall", s_nras[0], 0); chk("wr_ma_row", s_ma[0], 8'h12);
      chk("wr_ma_col", s_ma[1], 8'h34); chk("wr_nwe_early", s_nwe[1], 0);
      chk("wr_ncas_after_nwe", s_ncas[1], 1); chk("wr_ncas_fall", s_ncas[2], 0);
      repeat (3) @(negedge clk);
      traced(1'b0, 16'h1234, 8'h00, 8'hA5, 1, 1'b0, 16'h0, 8'h0, k1, k2);
      chk("rd_ack_edge", k1, 6);
      chk("rd_ma_row", s_ma[0], 8'h12); chk("rd_ma_col", s_ma[1], 8'h34);
      chk("rd_nwe_high", s_nwe[1], 1);
      repeat (4) @(negedge clk);
      chk("rdata_held", host.rdata, 8'hA5);

      // Collision: req arrives in the same IDLE cycle as a pending refresh
      sync_ref();
      rc = ref_count;
      g = 0;
      while (cyc < ref_cyc + REF_IV - 1 && g < 3 * REF_IV) begin
         @(negedge clk);
         g++;
      end
      a0 = ack_cnt;
      traced(1'b0, 16'h1234, 8'h00, 8'hA5, 1, 1'b0, 16'h0, 8'h0, k1, k2);
      chk("col_ref_first", s_nras[0], 0); chk("col_ref_ncas_high", s_ncas[0], 1);
      chk("col_ref_end", s_nras[5], 1); chk("col_acc_start", s_nras[6], 0);
      chk("col_acc_row", s_ma[6], 8'h12); chk("col_ack_edge", k1, 12);
      repeat (10) @(negedge clk);
      chk("col_one_ack", ack_cnt - a0, 1);
      chk("col_one_ref", ref_count - rc, 1);

      // Back-to-back: req held through ack, second access reads the first one's data
      sync_ref();
      traced(1'b1, 16'h0101, 8'h5A, 8'h00, 2, 1'b0, 16'h0101, 8'h5A, k1, k2);
      chk("b2b_ack1", k1, 6); chk("b2b_ack2", k2, 14);
      chk("b2b_ras_rise", s_nras[6], 1); chk("b2b_ras_pre", s_nras[7], 1);
      chk("b2b_ras_fall", s_nras[8], 0); chk("b2b_row", s_ma[8], 8'h01);

      // Reset during the CAS window of a write
      sync_ref();
      a0 = ack_cnt;
      host.we = 1'b1; host.addr = 16'h1234; host.wdata = 8'h3C; host.req = 1'b1;
      repeat (4) @(negedge clk);
      chk("rstmid_in_cas", ncas, 0);
      nreset = 1'b0;
      #1;
      chk("rstmid_nras", nras, 1); chk("rstmid_ncas", ncas, 1); chk("rstmid_nwe", nwe, 1);
      host.req = 1'b0;
      repeat (3) @(negedge clk);
      exp_ref_row = 8'd0; ref_hist.delete(); ref_count = 0;
      nreset = 1'b1;
      @(negedge clk);
      chk("rstmid_busy", host.busy, 0);
      chk("rstmid_no_ack", ack_cnt - a0, 0);
      traced(1'b0, 16'h1234, 8'h00, 8'hA5, 1, 1'b0, 16'h0, 8'h0, k1, k2);
      chk("rstmid_rd_ack_edge", k1, 6);

      // Refresh row wrap over 257 refreshes
      g = 0;
      while (ref_count < 257 && g < 257 * REF_IV + 500) begin
         @(negedge clk);
         g++;
      end
      chk("wrap_count", (ref_count >= 257), 1);
      chk("wrap_254", ref_hist[254], 8'd254);
      chk("wrap_255", ref_hist[255], 8'd255);
      chk("wrap_0", ref_hist[256], 8'd0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
